// File: rtl/qx1_id_ex_stage.sv
// qx1_id_ex_stage: ID/EX register with EX/MEM and MEM/WB forwarding and load-use stall.
module qx1_id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_rs1_val,
  input  logic [DATA_W-1:0] in_rs2_val,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_alu_ctrl,
  input  logic              in_reg_write,
  input  logic              in_is_load,
  input  logic              exm_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              exm_is_load,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2,
  output logic [2:0]        alu_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_is_load
);
  logic              valid, use_imm;
  logic [REG_AW-1:0] rs1, rs2;
  logic [DATA_W-1:0] v1, v2, imm;
  logic              hz, fire_out, cap;
  logic              exm_f1, exm_f2, wb_m1, wb_m2;
  always_comb begin
    exm_f1    = exm_en && !exm_is_load && exm_rd == rs1;
    exm_f2    = exm_en && !exm_is_load && exm_rd == rs2;
    wb_m1     = wb_en && wb_rd == rs1 && rs1 != '0;
    wb_m2     = wb_en && wb_rd == rs2 && rs2 != '0;
    src1      = rs1 == '0 ? '0 : exm_f1 ? exm_data : wb_m1 ? wb_data : v1;
    src2      = use_imm ? imm : rs2 == '0 ? '0 : exm_f2 ? exm_data : wb_m2 ? wb_data : v2;
    hz        = valid && exm_en && exm_is_load && exm_rd != '0 &&
                (exm_rd == rs1 || (!use_imm && exm_rd == rs2));
    out_valid = valid && !hz;
    fire_out  = out_valid && out_ready;
    in_ready  = !valid || fire_out;
    cap       = in_valid && in_ready;
  end
  // WB bypass on capture covers a register-file write and read in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid         <= 1'b0;
      rs1           <= '0;
      rs2           <= '0;
      out_rd        <= '0;
      v1            <= '0;
      v2            <= '0;
      imm           <= '0;
      use_imm       <= 1'b0;
      alu_ctrl      <= 3'b000;
      out_reg_write <= 1'b0;
      out_is_load   <= 1'b0;
    end else if (cap) begin
      valid         <= 1'b1;
      rs1           <= in_rs1;
      rs2           <= in_rs2;
      out_rd        <= in_rd;
      v1            <= (wb_en && wb_rd == in_rs1 && in_rs1 != '0) ? wb_data : in_rs1_val;
      v2            <= (wb_en && wb_rd == in_rs2 && in_rs2 != '0) ? wb_data : in_rs2_val;
      imm           <= in_imm;
      use_imm       <= in_use_imm;
      alu_ctrl      <= in_alu_ctrl;
      out_reg_write <= in_reg_write;
      out_is_load   <= in_is_load;
    end else begin
      if (fire_out) valid <= 1'b0;
      if (wb_m1) v1 <= wb_data;
      if (wb_m2) v2 <= wb_data;
    end
  end
endmodule

// File: tb/tb_qx1_id_ex_stage.sv
// tb_qx1_id_ex_stage: directed + random stimulus checked against a behavioural model every cycle.
module tb_qx1_id_ex_stage;
  logic        clk, rst_n;
  logic        in_valid, in_ready, in_use_imm, in_reg_write, in_is_load;
  logic [2:0]  in_rs1, in_rs2, in_rd, in_alu_ctrl;
  logic [15:0] in_rs1_val, in_rs2_val, in_imm;
  logic        exm_en, exm_is_load, wb_en;
  logic [2:0]  exm_rd, wb_rd;
  logic [15:0] exm_data, wb_data;
  logic [15:0] src1, src2;
  logic [2:0]  alu_ctrl, out_rd;
  logic        out_valid, out_ready, out_reg_write, out_is_load;
  int          n_tests = 0, n_fail = 0;
  bit          run = 0;

  qx1_id_ex_stage #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_alu_ctrl(in_alu_ctrl),
    .in_reg_write(in_reg_write), .in_is_load(in_is_load),
    .exm_en(exm_en), .exm_rd(exm_rd), .exm_data(exm_data), .exm_is_load(exm_is_load),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .src1(src1), .src2(src2), .alu_ctrl(alu_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_is_load(out_is_load)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    bit v; logic [2:0] rs1, rs2, rd, op; logic [15:0] v1, v2, imm; bit ui, rw, ld;
  } ent_t;
  ent_t m;

  function automatic logic [15:0] opnd(logic [2:0] r, logic [15:0] held);
    if (r == 0) return 16'h0;
    if (exm_en && !exm_is_load && exm_rd == r) return exm_data;
    if (wb_en && wb_rd == r) return wb_data;
    return held;
  endfunction

  function automatic bit exp_ov();
    bit stall = exm_en && exm_is_load && exm_rd != 0 &&
                (exm_rd == m.rs1 || (!m.ui && exm_rd == m.rs2));
    return m.v && !stall;
  endfunction

  function automatic bit exp_ir();
    return !m.v || (exp_ov() && out_ready);
  endfunction

  function automatic ent_t nxt();
    ent_t n = m;
    if (in_valid && exp_ir()) begin
      n.v = 1; n.rs1 = in_rs1; n.rs2 = in_rs2; n.rd = in_rd; n.op = in_alu_ctrl;
      n.imm = in_imm; n.ui = in_use_imm; n.rw = in_reg_write; n.ld = in_is_load;
      n.v1 = (wb_en && wb_rd == in_rs1 && in_rs1 != 0) ? wb_data : in_rs1_val;
      n.v2 = (wb_en && wb_rd == in_rs2 && in_rs2 != 0) ? wb_data : in_rs2_val;
    end else begin
      if (exp_ov() && out_ready) n.v = 0;
      if (m.v && wb_en && wb_rd != 0 && wb_rd == m.rs1) n.v1 = wb_data;
      if (m.v && wb_en && wb_rd != 0 && wb_rd == m.rs2) n.v2 = wb_data;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= '{default: 0};
    else m <= nxt();

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n && run) begin
      chk("model out_valid", out_valid, exp_ov());
      chk("model in_ready", in_ready, exp_ir());
      if (m.v) begin
        chk("model src1", src1, opnd(m.rs1, m.v1));
        chk("model src2", src2, m.ui ? m.imm : opnd(m.rs2, m.v2));
        chk("model alu_ctrl", alu_ctrl, m.op);
        chk("model out_rd", out_rd, m.rd);
        chk("model out_reg_write", out_reg_write, m.rw);
        chk("model out_is_load", out_is_load, m.ld);
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [2:0] r1, logic [2:0] r2, logic [2:0] rd,
                       logic [15:0] a, logic [15:0] b, logic [15:0] im,
                       logic ui, logic [2:0] op, logic rw, logic ld);
    in_valid = 1; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_rs1_val = a; in_rs2_val = b;
    in_imm = im; in_use_imm = ui; in_alu_ctrl = op; in_reg_write = rw; in_is_load = ld;
    tick();
    in_valid = 0;
  endtask

  initial begin
    rst_n = 1; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rs1_val = 0; in_rs2_val = 0;
    in_imm = 0; in_use_imm = 0; in_alu_ctrl = 0; in_reg_write = 0; in_is_load = 0;
    exm_en = 0; exm_rd = 0; exm_data = 0; exm_is_load = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
    #1 rst_n = 0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst src1", src1, 0);
    chk("rst src2", src2, 0);
    chk("rst alu_ctrl", alu_ctrl, 0);
    chk("rst out_rd", out_rd, 0);
    chk("rst out_reg_write", out_reg_write, 0);
    chk("rst out_is_load", out_is_load, 0);
    @(posedge clk); #1 rst_n = 1; run = 1;

    issue(3'd1, 3'd2, 3'd3, 16'd5, 16'd7, 16'd0, 0, 3'b000, 1, 0);
    @(negedge clk);
    chk("add src1", src1, 16'd5);
    chk("add src2", src2, 16'd7);
    chk("add alu_ctrl", alu_ctrl, 3'b000);
    chk("add out_valid", out_valid, 1);
    tick();

    out_ready = 0;
    issue(3'd3, 3'd0, 3'd1, 16'd1, 16'd0, 16'd0, 0, 3'b010, 1, 0);
    exm_en = 1; exm_rd = 3; exm_data = 16'h00AA; wb_en = 1; wb_rd = 3; wb_data = 16'h00BB;
    @(negedge clk);
    chk("fwd exm priority", src1, 16'h00AA);
    tick();
    exm_en = 0;
    @(negedge clk);
    chk("fwd wb", src1, 16'h00BB);
    tick();
    wb_en = 0; out_ready = 1;
    tick();

    out_ready = 0;
    issue(3'd0, 3'd0, 3'd1, 16'h5555, 16'h0, 16'h0, 0, 3'b000, 1, 0);
    exm_en = 1; exm_rd = 0; exm_data = 16'hFFFF;
    @(negedge clk);
    chk("r0 src1", src1, 16'h0);
    tick();
    exm_en = 0; out_ready = 1;
    tick();

    issue(3'd5, 3'd4, 3'd2, 16'd1, 16'h0BAD, 16'd0, 0, 3'b001, 1, 0);
    exm_en = 1; exm_rd = 4; exm_is_load = 1;
    @(negedge clk);
    chk("loaduse out_valid", out_valid, 0);
    chk("loaduse in_ready", in_ready, 0);
    tick();
    exm_en = 0; exm_is_load = 0; wb_en = 1; wb_rd = 4; wb_data = 16'h1234;
    @(negedge clk);
    chk("loaduse resolved out_valid", out_valid, 1);
    chk("loaduse resolved src2", src2, 16'h1234);
    tick();
    wb_en = 0;

    issue(3'd5, 3'd4, 3'd2, 16'd1, 16'h0BAD, 16'd9, 1, 3'b001, 1, 0);
    exm_en = 1; exm_rd = 4; exm_is_load = 1;
    @(negedge clk);
    chk("imm no stall out_valid", out_valid, 1);
    chk("imm src2", src2, 16'd9);
    tick();
    exm_en = 0; exm_is_load = 0;

    out_ready = 0;
    issue(3'd2, 3'd6, 3'd7, 16'h0011, 16'h0066, 16'd0, 0, 3'b011, 1, 1);
    wb_en = 1; wb_rd = 2; wb_data = 16'h0042;
    in_valid = 1; in_rs1 = 6; in_rs1_val = 16'h0077; in_rd = 5; in_alu_ctrl = 3'b111;
    in_is_load = 0;
    @(negedge clk);
    chk("bp in_ready", in_ready, 0);
    chk("bp out_valid", out_valid, 1);
    chk("bp src1 wb", src1, 16'h0042);
    tick();
    wb_en = 0;
    @(negedge clk);
    chk("bp refresh src1", src1, 16'h0042);
    chk("bp out_rd", out_rd, 3'd7);
    tick();
    @(negedge clk);
    chk("bp stable src1", src1, 16'h0042);
    chk("bp stable in_ready", in_ready, 0);
    chk("bp stable alu_ctrl", alu_ctrl, 3'b011);
    out_ready = 1;
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("replace src1", src1, 16'h0077);
    chk("replace out_rd", out_rd, 3'd5);
    chk("replace alu_ctrl", alu_ctrl, 3'b111);
    tick();

    out_ready = 0;
    issue(3'd1, 3'd2, 3'd3, 16'd3, 16'd4, 16'd0, 0, 3'b000, 1, 0);
    #2 rst_n = 0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1; out_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post rst no stale", out_valid, 0);
      tick();
    end

    repeat (80) begin
      in_valid = 1'($urandom); in_rs1 = 3'($urandom); in_rs2 = 3'($urandom);
      in_rd = 3'($urandom); in_rs1_val = 16'($urandom); in_rs2_val = 16'($urandom);
      in_imm = 16'($urandom); in_use_imm = 1'($urandom); in_alu_ctrl = 3'($urandom);
      in_reg_write = 1'($urandom); in_is_load = 1'($urandom);
      exm_en = 1'($urandom); exm_rd = 3'($urandom); exm_data = 16'($urandom);
      exm_is_load = 1'($urandom); wb_en = 1'($urandom); wb_rd = 3'($urandom);
      wb_data = 16'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/qx1_id_ex_stage.md
Name: qx1_id_ex_stage

Overview:
- ID/EX pipeline register of the QX1 16-bit core.
- Sits directly upstream of the ALU. It captures decoded operands and control from decode, and resolves data hazards by forwarding from the EX/MEM and MEM/WB stages.
- Stalls on load-use hazards.
- Presents src1, src2 and alu_ctrl to the ALU, with a valid/ready handshake toward the downstream EX/MEM register.

Parameters:
DATA_W, 16, operand/result width (matches ALU src1/src2/result)
REG_AW, 3, register index width (8 GPRs, r0 reads as zero)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept this cycle
in_rs1  input  REG_AW  source 1 index
in_rs2  input  REG_AW  source 2 index
in_rd  input  REG_AW  destination index
in_rs1_val  input  DATA_W  register-file value of rs1
in_rs2_val  input  DATA_W  register-file value of rs2
in_imm  input  DATA_W  sign/zero-extended immediate (extension done in decode)
in_use_imm  input  1  src2 = immediate instead of rs2
in_alu_ctrl  input  3  ALU op code (000 ADD … 111 SLT)
in_reg_write  input  1  instruction writes rd
in_is_load  input  1  instruction is a load
exm_en  input  1  EX/MEM stage holds a valid reg-writing instruction
exm_rd  input  REG_AW  its destination
exm_data  input  DATA_W  its ALU result
exm_is_load  input  1  EX/MEM instruction is a load (data not yet available)
wb_en  input  1  writeback writes a register this cycle
wb_rd  input  REG_AW  writeback destination
wb_data  input  DATA_W  writeback data
src1  output  DATA_W  ALU operand 1 (forwarded)
src2  output  DATA_W  ALU operand 2 (forwarded or immediate)
alu_ctrl  output  3  ALU op code
out_valid  output  1  issued instruction valid to EX/MEM
out_ready  input  1  EX/MEM accepts
out_rd  output  REG_AW  held rd
out_reg_write  output  1  held reg_write
out_is_load  output  1  held is_load

Behaviour:
Interface:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Reset:
- Held valid flag = 0 and all held fields = 0.
- Outputs: src1 = src2 = 0, alu_ctrl = 000, out_valid = 0, out_rd = 0, out_reg_write = 0, out_is_load = 0, in_ready = 1.
- Reset asserted mid-stall discards the held instruction. No partial state survives.

State: one entry {valid, rs1, rs2, rd, v1, v2, imm, use_imm, alu_ctrl, reg_write, is_load}.

Forwarding (combinational, from held entry and current buses), per source s in {rs1, rs2}:
- If s == 0 → operand = 0.
- Else if exm_en && exm_rd == s && !exm_is_load → exm_data.
- Else if wb_en && wb_rd == s → wb_data.
- Else the held value.
- EX/MEM has priority over WB.
- src2 = imm when use_imm, regardless of rs2.

Hazard:
- hz = valid && exm_en && exm_is_load && exm_rd != 0 && (exm_rd == rs1 || (!use_imm && exm_rd == rs2)).
- out_valid = valid && !hz, so a bubble is issued.
- Entry is held while hz; resolves once the load reaches WB and forwards.

Handshake:
- fire_out = out_valid && out_ready.
- in_ready = !valid || fire_out. Zero-bubble throughput when downstream is ready.
- Capture when in_valid && in_ready. A capture in the same cycle as fire_out replaces the entry.
- fire_out without capture clears valid.
- Held entry is stable while !fire_out.
- Stall refresh: while valid and not replaced, if wb_en && wb_rd matches held rs1/rs2 (nonzero), write wb_data into held v1/v2. This keeps the value after WB retires.
- On capture, the same WB bypass is applied to incoming rs*_val, covering the register-file write/read same-cycle case.

Width: all data DATA_W, no arithmetic performed here. alu_ctrl passes through unchanged.

Test Plan:
- Reset: rst_n low → out_valid = 0, src1 = src2 = 0, alu_ctrl = 000, in_ready = 1. Then ADD r1 = 5, r2 = 7 issued → next cycle src1 = 5, src2 = 7, alu_ctrl = 000, out_valid = 1.
- Forward priority: held rs1 = r3 (v = 1), exm_en/rd = 3/data = 0x00AA, wb_en/rd = 3/data = 0x00BB → src1 = 0x00AA. Drop exm_en → src1 = 0x00BB.
- r0 rule: rs1 = 0, exm_en, exm_rd = 0, exm_data = 0xFFFF → src1 = 0.
- Load-use: held SUB rs2 = r4, use_imm = 0, exm_is_load, exm_rd = 4 → out_valid = 0 and in_ready = 0 for 1 cycle. Next cycle wb_en rd = 4 data = 0x1234 → out_valid = 1, src2 = 0x1234. Same case with use_imm = 1, imm = 9 → no stall, src2 = 9.
- Backpressure: out_ready = 0 for 3 cycles → entry stable, in_ready = 0. wb_en rd = 2 = held rs1 during stall with data 0x0042 → after wb_en drops, src1 remains 0x0042.
- Async reset mid-stall: assert rst_n low between clock edges → out_valid = 0 immediately. After release no stale instruction issues.
